fir_out_sat_fifo: RTL and testbench

FIR_OUT_SAT_FIFO -- requirements
Module: fir_out_sat_fifo

---
 rtl/fir_out_sat_fifo_if.sv | 14 +
 rtl/fir_out_sat_fifo.sv | 122 ++++++++++++
 tb/tb_fir_out_sat_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_out_sat_fifo_if.sv
// AXI-Stream style handshake bundle used on both sides of the saturating
// output FIFO. The width is a parameter so the same bundle carries the wide
// FIR result on the input side and the narrow saturated sample on the output.
interface fir_out_sat_fifo_if #(
  parameter int pWIDTH = 32
) ();
  logic              tvalid;
  logic [pWIDTH-1:0] tdata;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fir_out_sat_fifo.sv
// Saturating first-word-fall-through FIFO behind the FIR output.
// Wide signed samples are clipped to pOUT_WIDTH on entry, buffered with their
// tlast marker, and presented downstream from a registered head so sm.tdata
// holds its last value while the FIFO is empty. Status counters track output
// beats and clipped inputs; frame_done is sticky once a tlast beat leaves.
module fir_out_sat_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pOUT_WIDTH  = 16,
  parameter int pDEPTH      = 8
) (
  input  logic                axis_clk,
  input  logic                axis_rst_n,
  fir_out_sat_fifo_if.slave   ss,
  fir_out_sat_fifo_if.master  sm,
  input  logic                clear,
  output logic [31:0]         sample_cnt,
  output logic [15:0]         sat_cnt,
  output logic                frame_done
);

  localparam int AW = $clog2(pDEPTH);
  localparam int CW = $clog2(pDEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(pDEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic                  ready_en;
  logic [pOUT_WIDTH-1:0] mem_data [pDEPTH];
  logic                  mem_last [pDEPTH];
  logic [pOUT_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [pOUT_WIDTH-1:0] nxt_data;
  logic                  nxt_last;
  logic [AW-1:0]         head_idx;
  logic [CW-1:0]         remaining;
  logic                  in_hs;
  logic                  out_hs;
  logic                  is_clip;
  logic [pOUT_WIDTH-1:0] sat_data;
  logic [pDATA_WIDTH-pOUT_WIDTH:0] in_hi;

  // ready_en keeps ss.tready low until the first clock edge after reset release
  assign ss.tready = ready_en && (occ != FULL_C);
  assign sm.tvalid = (occ != '0);
  assign sm.tdata  = out_data;
  assign sm.tlast  = out_last;

  assign in_hs  = ss.tvalid && ss.tready;
  assign out_hs = sm.tvalid && sm.tready;

  // A sample fits when every bit from the output sign bit upward matches
  assign in_hi    = ss.tdata[pDATA_WIDTH-1:pOUT_WIDTH-1];
  assign is_clip  = !((&in_hi) || !(|in_hi));
  assign sat_data = is_clip ? {ss.tdata[pDATA_WIDTH-1], {(pOUT_WIDTH-1){~ss.tdata[pDATA_WIDTH-1]}}}
                            : ss.tdata[pOUT_WIDTH-1:0];

  // Next head value: the stored entry behind the head, the incoming sample
  // when the FIFO drains to empty on this edge, or hold when nothing arrives
  always_comb begin
    head_idx  = out_hs ? rd_ptr + AW'(1) : rd_ptr;
    remaining = occ - CW'(out_hs);
    nxt_data  = out_data;
    nxt_last  = out_last;
    if (remaining != '0) begin
      nxt_data = mem_data[head_idx];
      nxt_last = mem_last[head_idx];
    end else if (in_hs) begin
      nxt_data = sat_data;
      nxt_last = ss.tlast;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge axis_clk) begin
    if (in_hs) begin
      mem_data[wr_ptr] <= sat_data;
      mem_last[wr_ptr] <= ss.tlast;
    end
  end

  // Pointers, occupancy, registered head and input-ready enable
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      ready_en <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      out_data <= nxt_data;
      out_last <= nxt_last;
      if (in_hs)  wr_ptr <= wr_ptr + AW'(1);
      if (out_hs) rd_ptr <= rd_ptr + AW'(1);
      case ({in_hs, out_hs})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Status counters and sticky frame flag; clear wins over same-edge updates
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sample_cnt <= '0;
      sat_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      sat_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (out_hs) sample_cnt <= sample_cnt + 32'd1;
      if (in_hs && is_clip && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
      if (out_hs && out_last) frame_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_sat_fifo.sv
// Bench for the saturating output FIFO. Stimulus tasks push the expected
// saturated beat into a queue at acceptance; a negedge monitor keeps an
// occupancy/counter model and compares every presented head against the queue.
module tb_fir_out_sat_fifo;

  localparam int DEPTH = 8;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } beat_t;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        clear;
  logic [31:0] sample_cnt;
  logic [15:0] sat_cnt;
  logic        frame_done;

  fir_out_sat_fifo_if #(.pWIDTH(32)) ss_if ();
  fir_out_sat_fifo_if #(.pWIDTH(16)) sm_if ();

  fir_out_sat_fifo #(.pDATA_WIDTH(32), .pOUT_WIDTH(16), .pDEPTH(DEPTH)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .ss         (ss_if),
    .sm         (sm_if),
    .clear      (clear),
    .sample_cnt (sample_cnt),
    .sat_cnt    (sat_cnt),
    .frame_done (frame_done)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_acc   = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$];

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [31:0] d);
    int v;
    v = $signed(d);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // sm.tready pattern: 0 always ready, 1 stalled, 2 random, 3 driven by the test
  task automatic set_mode(input int m);
    rdy_mode = m;
    if (m == 0) sm_if.tready = 1'b1;
    if (m == 1) sm_if.tready = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge axis_clk);
      #1;
      case (rdy_mode)
        0: sm_if.tready = 1'b1;
        1: sm_if.tready = 1'b0;
        2: sm_if.tready = 1'($urandom_range(1));
        default: ;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    beat_t e;
    n = 0;
    ss_if.tvalid = 1'b1;
    ss_if.tdata  = d;
    ss_if.tlast  = l;
    @(negedge axis_clk);
    while (!ss_if.tready && n < 200) begin
      @(negedge axis_clk);
      n++;
    end
    chk("send_accept_timeout", 64'(ss_if.tready), 64'(1));
    if (ss_if.tready) begin
      e.d = sat16(d);
      e.l = l;
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge axis_clk);
    #1;
    ss_if.tvalid = 1'b0;
    ss_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sm_if.tvalid) && n < 3000) begin
      @(posedge axis_clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge axis_clk);
    #1;
    clear = 1'b0;
  endtask

  // Reference model and scoreboard monitor
  int          occ_m   = 0;
  bit          armed_m = 0;
  logic [15:0] hold_m  = '0;
  logic [31:0] es_m    = '0;
  logic [15:0] esat_m  = '0;
  bit          efd_m   = 0;

  initial begin
    bit    exp_ready;
    bit    in_hs;
    bit    out_hs;
    int    v;
    beat_t e;
    forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
        chk("rst_ss_tready", 64'(ss_if.tready), 64'(0));
        chk("rst_sm_tvalid", 64'(sm_if.tvalid), 64'(0));
        chk("rst_sm_tdata", 64'(sm_if.tdata), 64'(0));
        chk("rst_sm_tlast", 64'(sm_if.tlast), 64'(0));
        chk("rst_sample_cnt", 64'(sample_cnt), 64'(0));
        chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        exp_q.delete();
        occ_m = 0; armed_m = 0; hold_m = '0;
        es_m = '0; esat_m = '0; efd_m = 0;
      end else begin
        exp_ready = armed_m && (occ_m < DEPTH);
        chk("ss_tready", 64'(ss_if.tready), 64'(exp_ready));
        chk("sm_tvalid", 64'(sm_if.tvalid), 64'(occ_m > 0));
        if (occ_m > 0) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: model holds %0d beats but queue is empty", occ_m);
          end else begin
            chk("head_tdata", 64'(sm_if.tdata), 64'(exp_q[0].d));
            chk("head_tlast", 64'(sm_if.tlast), 64'(exp_q[0].l));
          end
        end else begin
          chk("empty_tdata_hold", 64'(sm_if.tdata), 64'(hold_m));
        end
        chk("sample_cnt", 64'(sample_cnt), 64'(es_m));
        chk("sat_cnt", 64'(sat_cnt), 64'(esat_m));
        chk("frame_done", 64'(frame_done), 64'(efd_m));

        in_hs  = ss_if.tvalid && exp_ready;
        out_hs = (occ_m > 0) && sm_if.tready;
        if (out_hs && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          hold_m = e.d;
          es_m++;
          if (e.l) efd_m = 1;
        end
        if (in_hs) begin
          v = $signed(ss_if.tdata);
          if ((v > 32767 || v < -32768) && esat_m != 16'hFFFF) esat_m++;
        end
        occ_m = occ_m + int'(in_hs) - int'(out_hs);
        if (clear) begin
          es_m = '0; esat_m = '0; efd_m = 0;
        end
        armed_m = 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    axis_rst_n   = 1'b0;
    clear        = 1'b0;
    ss_if.tvalid = 1'b0;
    ss_if.tdata  = '0;
    ss_if.tlast  = 1'b0;
    sm_if.tready = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    #1;
    chk("tready_before_first_edge", 64'(ss_if.tready), 64'(0));
    @(posedge axis_clk);
    #1;
    chk("tready_after_first_edge", 64'(ss_if.tready), 64'(1));

    // Pass-through of 600 in-range samples, last one tagged
    set_mode(0);
    for (int i = 0; i < 600; i++) begin
      d = $urandom();
      d = {{16{d[15]}}, d[15:0]};
      send(d, 1'(i == 599));
    end
    wait_drain();
    chk("pt_sample_cnt", 64'(sample_cnt), 64'(600));
    chk("pt_sat_cnt", 64'(sat_cnt), 64'(0));
    chk("pt_frame_done", 64'(frame_done), 64'(1));

    // Saturation corners
    pulse_clear();
    send(32'd40000, 1'b0);
    send(32'(-40000), 1'b0);
    send(32'd32767, 1'b0);
    send(32'(-32768), 1'b0);
    send(32'd70000, 1'b1);
    wait_drain();
    chk("sat_sat_cnt", 64'(sat_cnt), 64'(3));
    chk("sat_sample_cnt", 64'(sample_cnt), 64'(5));

    // Backpressure: only DEPTH beats fit while the sink stalls
    set_mode(1);
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'(i * 111 - 500), 1'b0);
      end
      begin
        repeat (16) @(posedge axis_clk);
        #1;
        chk("bp_accepted", 64'(n_acc), 64'(DEPTH));
        chk("bp_tready_full", 64'(ss_if.tready), 64'(0));
        set_mode(0);
      end
    join
    wait_drain();
    chk("bp_total_accepted", 64'(n_acc), 64'(10));

    // Steady push and pop at occupancy 4, pointers wrapping repeatedly
    set_mode(1);
    for (int i = 0; i < 4; i++) send(32'(1000 + i), 1'b0);
    set_mode(0);
    for (int i = 0; i < 20; i++) send(32'(2000 + i * 3), 1'b0);
    wait_drain();

    // Clear on the same edge as the tlast output handshake
    set_mode(1);
    send(32'd11, 1'b0);
    send(32'd22, 1'b1);
    send(32'd33, 1'b0);
    set_mode(3);
    sm_if.tready = 1'b1;
    @(posedge axis_clk);
    #1;
    clear = 1'b1;
    @(posedge axis_clk);
    #1;
    clear = 1'b0;
    chk("clr_frame_done", 64'(frame_done), 64'(0));
    chk("clr_sample_cnt", 64'(sample_cnt), 64'(0));
    set_mode(0);
    wait_drain();
    chk("clr_drain_cnt", 64'(sample_cnt), 64'(1));

    // Random traffic with random sink readiness and full-range inputs
    set_mode(2);
    for (int i = 0; i < 300; i++) begin
      d = $urandom();
      if ($urandom_range(1) == 1) d = {{16{d[15]}}, d[15:0]};
      send(d, 1'($urandom_range(7) == 0));
      repeat ($urandom_range(2)) begin
        @(posedge axis_clk);
        #1;
      end
    end
    set_mode(0);
    wait_drain();

    // Reset with 5 beats buffered
    set_mode(1);
    for (int i = 0; i < 5; i++) send(32'(-7 * i - 3), 1'b0);
    axis_rst_n = 1'b0;
    #1;
    chk("mid_rst_sm_tvalid", 64'(sm_if.tvalid), 64'(0));
    chk("mid_rst_sample_cnt", 64'(sample_cnt), 64'(0));
    chk("mid_rst_ss_tready", 64'(ss_if.tready), 64'(0));
    repeat (2) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    set_mode(0);
    @(posedge axis_clk);
    #1;
    chk("post_rst_empty", 64'(sm_if.tvalid), 64'(0));
    send(32'd4242, 1'b0);
    send(32'(-4242), 1'b1);
    send(32'd100000, 1'b0);
    wait_drain();
    chk("post_rst_sample_cnt", 64'(sample_cnt), 64'(3));
    chk("post_rst_sat_cnt", 64'(sat_cnt), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
